// File: rtl/ps_alu_issue_pkg.sv
// ps_alu_issue_pkg: ALU opcode constants, condition codes and the ASTAT flag bundle
package ps_alu_issue_pkg;
  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_ADDC = 6'b000010;
  localparam logic [5:0] ALU_SUBB = 6'b000011;
  localparam logic [5:0] ALU_COMP = 6'b000101;
  typedef enum logic [3:0] {
    CC_EQ = 4'd0, CC_NE, CC_LT, CC_GE, CC_LE, CC_GT, CC_AC, CC_NAC, CC_AV, CC_NAV, CC_TRUE = 4'd15
  } cc_e;
  typedef struct packed {
    logic az;
    logic an;
    logic ac;
    logic av;
  } flags_t;
  // add/sub-with-carry consume ASTAT.AC as carry in
  function automatic logic uses_ci(input logic [5:0] op);
    return op[5:1] == 5'b00001;
  endfunction
endpackage

// File: rtl/ps_alu_issue_cond.sv
// ps_cond_eval: evaluates a condition code against the ASTAT flags
module ps_cond_eval
  import ps_alu_issue_pkg::*;
(
  input  logic [3:0] i_cond,
  input  flags_t     i_flags,
  output logic       o_pass
);
  logic [15:0] w_tab;
  // one bit per condition code, indexed by the code itself; 10..14 are never true
  assign w_tab = {1'b1, 5'b0, ~i_flags.av, i_flags.av, ~i_flags.ac, i_flags.ac,
                  ~i_flags.an & ~i_flags.az, i_flags.an | i_flags.az,
                  ~i_flags.an, i_flags.an, ~i_flags.az, i_flags.az};
  assign o_pass = w_tab[i_cond];
endmodule

// File: rtl/ps_alu_issue.sv
// ps_alu_issue: issues decoded compute ops to the ALU, tracks ASTAT and drives the RF write
module ps_alu_issue
  import ps_alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RA_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ins_vld,
  output logic                  ins_rdy,
  input  logic [5:0]            ins_op,
  input  logic [3:0]            ins_cond,
  input  logic [RA_WIDTH-1:0]   ins_dst,
  input  logic                  mode_alusat,
  input  logic                  sticky_clr,
  output logic                  ps_alu_en,
  output logic                  ps_alu_log,
  output logic [1:0]            ps_alu_hc,
  output logic [2:0]            ps_alu_sc,
  output logic                  ps_alu_sat,
  output logic                  ps_alu_ci,
  input  logic                  alu_ps_az,
  input  logic                  alu_ps_an,
  input  logic                  alu_ps_ac,
  input  logic                  alu_ps_av,
  input  logic                  alu_ps_compd,
  input  logic [DATA_WIDTH-1:0] alu_xb_dt,
  output logic                  rf_we,
  output logic [RA_WIDTH-1:0]   rf_wa,
  output logic [DATA_WIDTH-1:0] rf_wd,
  output logic                  astat_az,
  output logic                  astat_an,
  output logic                  astat_ac,
  output logic                  astat_av,
  output logic                  astat_aos,
  output logic [7:0]            astat_cacc
);
  flags_t              r_astat;
  logic                r_e, r_r;
  logic [RA_WIDTH-1:0] r_e_dst;
  logic                w_dep, w_acc, w_pass, w_go;
  // conditional and carry-consuming ops need ASTAT settled, so they wait for an empty pipe
  assign w_dep   = (ins_cond != CC_TRUE) | uses_ci(ins_op);
  assign ins_rdy = ~reset & ~((r_e | r_r) & w_dep);
  assign w_acc   = ins_vld & ins_rdy;
  assign w_go    = w_acc & w_pass;
  ps_cond_eval u_cond (
    .i_cond (ins_cond),
    .i_flags(r_astat),
    .o_pass (w_pass)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e        <= 1'b0;
      r_r        <= 1'b0;
      r_e_dst    <= '0;
      rf_wa      <= '0;
      ps_alu_log <= 1'b0;
      ps_alu_hc  <= '0;
      ps_alu_sc  <= '0;
      ps_alu_sat <= 1'b0;
      ps_alu_ci  <= 1'b0;
      r_astat    <= '0;
      astat_aos  <= 1'b0;
      astat_cacc <= '0;
    end else begin
      r_e <= w_go;
      r_r <= r_e;
      if (w_go) begin
        {ps_alu_log, ps_alu_hc, ps_alu_sc} <= ins_op;
        ps_alu_sat <= mode_alusat;
        ps_alu_ci  <= r_astat.ac;
        r_e_dst    <= ins_dst;
      end
      if (r_e) rf_wa <= r_e_dst;
      if (r_r) r_astat <= {alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av};
      if (r_r & alu_ps_compd) astat_cacc <= {astat_cacc[6:0], alu_ps_an};
      astat_aos <= (r_r & alu_ps_av) | (astat_aos & ~sticky_clr);
    end
  end
  assign ps_alu_en = r_e & ~reset;
  assign rf_we     = r_r & ~reset;
  assign rf_wd     = rf_we ? alu_xb_dt : '0;
  assign {astat_az, astat_an, astat_ac, astat_av} = r_astat;
endmodule

// File: tb/tb_ps_alu_issue.sv
// tb_ps_alu_issue: directed and randomized checks of ps_alu_issue against a queue-based reference model
module tb_ps_alu_issue;
  import ps_alu_issue_pkg::*;
  logic        clk = 1'b0;
  logic        reset, ins_vld, ins_rdy, mode_alusat, sticky_clr;
  logic [5:0]  ins_op;
  logic [3:0]  ins_cond, ins_dst, rf_wa;
  logic        ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_ci;
  logic [1:0]  ps_alu_hc;
  logic [2:0]  ps_alu_sc;
  logic        alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd;
  logic [15:0] alu_xb_dt, rf_wd;
  logic        rf_we, astat_az, astat_an, astat_ac, astat_av, astat_aos;
  logic [7:0]  astat_cacc;

  ps_alu_issue #(.DATA_WIDTH(16), .RA_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_op(ins_op),
    .ins_cond(ins_cond), .ins_dst(ins_dst), .mode_alusat(mode_alusat), .sticky_clr(sticky_clr),
    .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_hc(ps_alu_hc), .ps_alu_sc(ps_alu_sc),
    .ps_alu_sat(ps_alu_sat), .ps_alu_ci(ps_alu_ci), .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an),
    .alu_ps_ac(alu_ps_ac), .alu_ps_av(alu_ps_av), .alu_ps_compd(alu_ps_compd), .alu_xb_dt(alu_xb_dt),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .astat_az(astat_az), .astat_an(astat_an),
    .astat_ac(astat_ac), .astat_av(astat_av), .astat_aos(astat_aos), .astat_cacc(astat_cacc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  dst;
    logic        ci, sat;
    logic [15:0] res;
    logic        az, an, ac, av, compd;
    int          age;
  } ent_t;

  ent_t        q[$];
  ent_t        e_ent;
  logic        m_az, m_an, m_ac, m_av, m_aos;
  logic [7:0]  m_cacc;
  logic        e_rdy, e_en, e_we, last_acc;
  logic [3:0]  e_wa;
  logic [15:0] e_wd, op_a, op_b;
  int          nchk = 0, nerr = 0;
  logic [5:0]  ops [5] = '{ALU_ADD, ALU_SUB, ALU_ADDC, ALU_SUBB, ALU_COMP};
  logic [15:0] bnd [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

  function automatic logic cond_ok(input logic [3:0] c);
    case (c)
      4'd0:    return m_az;
      4'd1:    return !m_az;
      4'd2:    return m_an;
      4'd3:    return !m_an;
      4'd4:    return m_an || m_az;
      4'd5:    return !m_an && !m_az;
      4'd6:    return m_ac;
      4'd7:    return !m_ac;
      4'd8:    return m_av;
      4'd9:    return !m_av;
      4'd15:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ent_t alu_calc(input logic [5:0] op, input logic [15:0] a, b, input logic ci, sat);
    ent_t r;
    logic sub, cin;
    logic [15:0] bb;
    int ss;
    int unsigned us;
    sub = (op == ALU_SUB) || (op == ALU_SUBB) || (op == ALU_COMP);
    bb = sub ? ~b : b;
    cin = (op == ALU_ADDC || op == ALU_SUBB) ? ci : sub;
    us = 32'(a) + 32'(bb) + 32'(cin);
    ss = int'($signed(a)) + (sub ? -int'($signed(b)) : int'($signed(b)))
       + ((op == ALU_ADDC) ? int'(ci) : (op == ALU_SUBB) ? int'(ci) - 1 : 0);
    r.av = (ss > 32767) || (ss < -32768);
    r.res = (sat && r.av) ? ((ss > 0) ? 16'h7FFF : 16'h8000) : us[15:0];
    r.ac = us[16];
    r.az = (r.res == 16'h0000);
    r.an = r.res[15];
    r.compd = (op == ALU_COMP);
    r.op = op;
    r.ci = ci;
    r.sat = sat;
    r.dst = '0;
    r.age = 0;
    return r;
  endfunction

  function automatic logic [15:0] rval();
    return ($urandom_range(3) == 0) ? bnd[$urandom_range(4)] : 16'($urandom);
  endfunction

  // drive the ALU answer for the op in R and derive the expected outputs for this cycle
  task automatic eval_settle();
    e_en = 1'b0;
    e_we = 1'b0;
    e_wa = '0;
    e_wd = '0;
    alu_xb_dt = 16'($urandom);
    {alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd} = 5'($urandom);
    foreach (q[i]) begin
      if (q[i].age == 1) begin
        e_en = !reset;
        e_ent = q[i];
      end
      if (q[i].age == 2) begin
        e_we = !reset;
        e_wa = q[i].dst;
        e_wd = reset ? 16'h0 : q[i].res;
        alu_xb_dt = q[i].res;
        {alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd} = {q[i].az, q[i].an, q[i].ac, q[i].av, q[i].compd};
      end
    end
    e_rdy = !reset && !(q.size() > 0 && (ins_cond != 4'd15 || ins_op == ALU_ADDC || ins_op == ALU_SUBB));
    #1;
  endtask

  task automatic tick();
    logic acc, pass, rv, rav;
    ent_t n;
    ent_t nq[$];
    acc = ins_vld && e_rdy;
    pass = cond_ok(ins_cond);
    n = alu_calc(ins_op, op_a, op_b, m_ac, mode_alusat);
    n.dst = ins_dst;
    n.age = 1;
    @(posedge clk);
    last_acc = acc;
    if (reset) begin
      q.delete();
      {m_az, m_an, m_ac, m_av, m_aos} = '0;
      m_cacc = '0;
    end else begin
      rv = 1'b0;
      rav = 1'b0;
      foreach (q[i]) begin
        if (q[i].age == 2) begin
          rv = 1'b1;
          rav = q[i].av;
          {m_az, m_an, m_ac, m_av} = {q[i].az, q[i].an, q[i].ac, q[i].av};
          if (q[i].compd) m_cacc = {m_cacc[6:0], q[i].an};
        end else begin
          ent_t t;
          t = q[i];
          t.age = 2;
          nq.push_back(t);
        end
      end
      m_aos = (rv && rav) || (m_aos && !sticky_clr);
      if (acc && pass) nq.push_back(n);
      q = nq;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [5:0] op, input logic [3:0] cond, dst, input logic [15:0] a, b);
    int w;
    ins_vld = 1'b1; ins_op = op; ins_cond = cond; ins_dst = dst; op_a = a; op_b = b;
    w = 0;
    do begin
      eval_settle();
      tick();
      w++;
    end while (!last_acc && w < 10);
    ins_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    ins_vld = 1'b0;
    repeat (n) begin
      eval_settle();
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ins_vld = 1'b1; ins_op = ALU_ADD; ins_cond = 4'd15; ins_dst = 4'd1;
    op_a = 16'd3; op_b = 16'd4; mode_alusat = 1'b0; sticky_clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      eval_settle();
      nchk++; if (ins_rdy !== 1'b0) begin nerr++; $display("FAIL reset_rdy cyc=%0d got=%b exp=0", c, ins_rdy); end
      nchk++; if (ps_alu_en !== 1'b0) begin nerr++; $display("FAIL reset_en cyc=%0d got=%b exp=0", c, ps_alu_en); end
      nchk++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL reset_we cyc=%0d got=%b exp=0", c, rf_we); end
      tick();
    end
    eval_settle();
    nchk++; if ({astat_az, astat_an, astat_ac, astat_av, astat_aos, astat_cacc} !== 13'h0) begin
      nerr++; $display("FAIL reset_astat got=%b%b%b%b%b cacc=%h exp=0", astat_az, astat_an, astat_ac, astat_av, astat_aos, astat_cacc);
    end
    reset = 1'b0;
    eval_settle();
    nchk++; if (ins_rdy !== 1'b1) begin nerr++; $display("FAIL reset_release_rdy got=%b exp=1", ins_rdy); end
    tick();
    idle(3);
  endtask

  task automatic test_back_to_back();
    ins_vld = 1'b1; ins_op = ALU_ADD; ins_cond = 4'd15; ins_dst = 4'd1; op_a = 16'h0003; op_b = 16'h0004;
    eval_settle();
    nchk++; if (ins_rdy !== 1'b1) begin nerr++; $display("FAIL b2b_rdy1 got=%b exp=1", ins_rdy); end
    tick();
    ins_op = ALU_SUB; ins_dst = 4'd2; op_a = 16'h0002; op_b = 16'h0005;
    eval_settle();
    nchk++; if (ins_rdy !== 1'b1) begin nerr++; $display("FAIL b2b_rdy2 got=%b exp=1", ins_rdy); end
    nchk++; if (ps_alu_en !== 1'b1) begin nerr++; $display("FAIL b2b_en1 got=%b exp=1", ps_alu_en); end
    tick();
    ins_vld = 1'b0;
    eval_settle();
    nchk++; if (ps_alu_en !== 1'b1) begin nerr++; $display("FAIL b2b_en2 got=%b exp=1", ps_alu_en); end
    nchk++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd1, 16'h0007}) begin nerr++; $display("FAIL b2b_wr1 got=%b/%h/%h exp=1/1/0007", rf_we, rf_wa, rf_wd); end
    tick();
    eval_settle();
    nchk++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd2, 16'hFFFD}) begin nerr++; $display("FAIL b2b_wr2 got=%b/%h/%h exp=1/2/fffd", rf_we, rf_wa, rf_wd); end
    tick();
    eval_settle();
    nchk++; if ({astat_az, astat_an} !== 2'b01) begin nerr++; $display("FAIL b2b_flags az/an got=%b%b exp=01", astat_az, astat_an); end
    tick();
  endtask

  task automatic test_overflow_sticky();
    mode_alusat = 1'b0;
    send(ALU_ADD, 4'd15, 4'd3, 16'h7FFF, 16'h0001);
    idle(2);
    eval_settle();
    nchk++; if ({astat_av, astat_aos} !== 2'b11) begin nerr++; $display("FAIL ovf_set av/aos got=%b%b exp=11", astat_av, astat_aos); end
    tick();
    send(ALU_ADD, 4'd15, 4'd3, 16'h0001, 16'h0001);
    idle(2);
    eval_settle();
    nchk++; if ({astat_av, astat_aos} !== 2'b01) begin nerr++; $display("FAIL ovf_hold av/aos got=%b%b exp=01", astat_av, astat_aos); end
    tick();
    sticky_clr = 1'b1;
    eval_settle();
    tick();
    sticky_clr = 1'b0;
    eval_settle();
    nchk++; if (astat_aos !== 1'b0) begin nerr++; $display("FAIL sticky_clr aos got=%b exp=0", astat_aos); end
    tick();
    send(ALU_ADD, 4'd15, 4'd3, 16'h7FFF, 16'h0001);
    idle(1);
    sticky_clr = 1'b1;
    eval_settle();
    tick();
    sticky_clr = 1'b0;
    eval_settle();
    nchk++; if (astat_aos !== 1'b1) begin nerr++; $display("FAIL sticky_set_wins aos got=%b exp=1", astat_aos); end
    tick();
  endtask

  task automatic test_hazard();
    send(ALU_COMP, 4'd15, 4'd4, 16'd5, 16'd5);
    ins_vld = 1'b1; ins_op = ALU_ADD; ins_cond = 4'd0; ins_dst = 4'd6; op_a = 16'd0; op_b = 16'd0;
    for (int c = 0; c < 2; c++) begin
      eval_settle();
      nchk++; if (ins_rdy !== 1'b0) begin nerr++; $display("FAIL haz_stall cyc=%0d got=%b exp=0", c, ins_rdy); end
      tick();
    end
    eval_settle();
    nchk++; if (ins_rdy !== 1'b1) begin nerr++; $display("FAIL haz_accept got=%b exp=1", ins_rdy); end
    tick();
    ins_vld = 1'b0;
    eval_settle();
    nchk++; if (ps_alu_en !== 1'b1) begin nerr++; $display("FAIL haz_eq_en got=%b exp=1", ps_alu_en); end
    tick();
    eval_settle();
    nchk++; if ({rf_we, rf_wa} !== {1'b1, 4'd6}) begin nerr++; $display("FAIL haz_eq_wr got=%b/%h exp=1/6", rf_we, rf_wa); end
    tick();
    eval_settle();
    nchk++; if (astat_az !== 1'b1) begin nerr++; $display("FAIL haz_eq_az got=%b exp=1", astat_az); end
    tick();
    send(ALU_COMP, 4'd15, 4'd4, 16'd5, 16'd5);
    ins_vld = 1'b1; ins_op = ALU_ADD; ins_cond = 4'd1; ins_dst = 4'd7; op_a = 16'd1; op_b = 16'd1;
    eval_settle(); tick();
    eval_settle(); tick();
    eval_settle();
    nchk++; if (ins_rdy !== 1'b1) begin nerr++; $display("FAIL haz_ne_accept got=%b exp=1", ins_rdy); end
    tick();
    ins_vld = 1'b0;
    eval_settle();
    nchk++; if (ps_alu_en !== 1'b0) begin nerr++; $display("FAIL haz_ne_en got=%b exp=0", ps_alu_en); end
    tick();
    eval_settle();
    nchk++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL haz_ne_we got=%b exp=0", rf_we); end
    tick();
  endtask

  task automatic test_carry_chain();
    send(ALU_ADD, 4'd15, 4'd5, 16'hFFFF, 16'h0001);
    ins_vld = 1'b1; ins_op = ALU_ADDC; ins_cond = 4'd15; ins_dst = 4'd8; op_a = 16'd0; op_b = 16'd0;
    eval_settle();
    nchk++; if (ins_rdy !== 1'b0) begin nerr++; $display("FAIL carry_stall got=%b exp=0", ins_rdy); end
    tick();
    eval_settle(); tick();
    eval_settle();
    nchk++; if (ins_rdy !== 1'b1) begin nerr++; $display("FAIL carry_accept got=%b exp=1", ins_rdy); end
    tick();
    ins_vld = 1'b0;
    eval_settle();
    nchk++; if ({ps_alu_en, ps_alu_ci} !== 2'b11) begin nerr++; $display("FAIL carry_ci en/ci got=%b%b exp=11", ps_alu_en, ps_alu_ci); end
    tick();
    eval_settle();
    nchk++; if (rf_wd !== 16'h0001) begin nerr++; $display("FAIL carry_wd got=%h exp=0001", rf_wd); end
    tick();
  endtask

  task automatic test_cacc();
    send(ALU_COMP, 4'd15, 4'd9, 16'd1, 16'd2);
    send(ALU_COMP, 4'd15, 4'd9, 16'd3, 16'd2);
    idle(2);
    eval_settle();
    nchk++; if (astat_cacc !== 8'b0000_0010) begin nerr++; $display("FAIL cacc_hist got=%b exp=00000010", astat_cacc); end
    tick();
    send(ALU_ADD, 4'd15, 4'd10, 16'hFFFF, 16'h0001);
    idle(1);
    reset = 1'b1;
    eval_settle();
    nchk++; if (rf_we !== 1'b0) begin nerr++; $display("FAIL rst_mid_we got=%b exp=0", rf_we); end
    tick();
    reset = 1'b0;
    eval_settle();
    nchk++; if ({rf_we, astat_az, astat_ac, astat_cacc} !== 11'h0) begin
      nerr++; $display("FAIL rst_mid_state we/az/ac/cacc got=%b/%b/%b/%h exp=0", rf_we, astat_az, astat_ac, astat_cacc);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(49) == 0);
      sticky_clr = ($urandom_range(9) == 0);
      mode_alusat = 1'($urandom);
      if (!(ins_vld && !last_acc)) begin
        ins_vld = ($urandom_range(9) < 7);
        ins_op = ops[$urandom_range(4)];
        ins_cond = $urandom_range(1) ? 4'd15 : 4'($urandom_range(15));
        ins_dst = 4'($urandom);
        op_a = rval();
        op_b = rval();
      end
      eval_settle();
      nchk++; if (ins_rdy !== e_rdy) begin nerr++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", c, ins_rdy, e_rdy); end
      nchk++; if (ps_alu_en !== e_en) begin nerr++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", c, ps_alu_en, e_en); end
      nchk++; if (rf_we !== e_we) begin nerr++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, rf_we, e_we); end
      nchk++; if ({astat_az, astat_an, astat_ac, astat_av} !== {m_az, m_an, m_ac, m_av}) begin
        nerr++; $display("FAIL rnd_flags cyc=%0d got=%b%b%b%b exp=%b%b%b%b", c, astat_az, astat_an, astat_ac, astat_av, m_az, m_an, m_ac, m_av);
      end
      nchk++; if (astat_aos !== m_aos) begin nerr++; $display("FAIL rnd_aos cyc=%0d got=%b exp=%b", c, astat_aos, m_aos); end
      nchk++; if (astat_cacc !== m_cacc) begin nerr++; $display("FAIL rnd_cacc cyc=%0d got=%h exp=%h", c, astat_cacc, m_cacc); end
      if (e_we) begin
        nchk++; if ({rf_wa, rf_wd} !== {e_wa, e_wd}) begin nerr++; $display("FAIL rnd_wr cyc=%0d got=%h/%h exp=%h/%h", c, rf_wa, rf_wd, e_wa, e_wd); end
      end
      if (e_en) begin
        nchk++; if ({ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci} !== {e_ent.op, e_ent.sat, e_ent.ci}) begin
          nerr++; $display("FAIL rnd_issue cyc=%0d got=%b%b%b/%b/%b exp=%b/%b/%b", c, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, ps_alu_ci, e_ent.op, e_ent.sat, e_ent.ci);
        end
      end
      tick();
    end
    reset = 1'b0;
    sticky_clr = 1'b0;
    idle(3);
  endtask

  initial begin
    last_acc = 1'b0;
    test_reset();
    test_back_to_back();
    test_overflow_sticky();
    test_hazard();
    test_carry_chain();
    test_cacc();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
